// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue interface: fetch-side offer, decode-side head, flush and occupancy.
// master = surrounding pipeline (drives offers, out_ready, flush); slave = the queue itself.
// Payload fields are flat 32-bit/1-bit signals so the pipeline can wire them directly.
interface instr_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_inslot;
    logic          in_adel;
    logic [31:0]   in_badvaddr;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [31:0]   out_badvaddr;
    logic          out_inslot;
    logic          out_adel;

    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, in_inslot, in_adel, in_badvaddr,
        output out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_badvaddr, out_inslot, out_adel, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_inslot, in_adel, in_badvaddr,
        input  out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_badvaddr, out_inslot, out_adel, count
    );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode; DEPTH entries (power of two, >= 2).
// Latency: one cycle push-to-head; with INSTR_QUEUE_BYPASS_EN an empty queue forwards in_* the same cycle.
// Backpressure: in_ready = !full from registered count only; flush drops everything and wins over push/pop.
module instr_queue #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetn,
    instr_queue_if.slave q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] badvaddr;
        logic        inslot;
        logic        adel;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_ent;
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            empty;
    logic            push;
    logic            pop;

    assign empty      = (count_q == '0);
    assign q.in_ready = (count_q != CW'(DEPTH));
    assign q.count    = count_q;

    // Normalise the offered entry: a faulting fetch carries no instruction, a good one no bad address.
    always_comb begin
        in_ent        = '0;
        in_ent.pc     = q.in_pc;
        in_ent.inslot = q.in_inslot;
        in_ent.adel   = q.in_adel;
        if (q.in_adel) begin
            in_ent.badvaddr = q.in_badvaddr;
        end else begin
            in_ent.instr = q.in_instr;
        end
    end

`ifdef INSTR_QUEUE_BYPASS_EN
    logic byp;
    // Empty queue with a live offer: present it straight to decode.
    assign byp = empty & q.in_valid & ~q.flush;

    // Head selection: stored entry first, then the bypassed offer, otherwise all-zero payload.
    always_comb begin
        head        = '0;
        q.out_valid = 1'b0;
        if (!empty) begin
            head        = mem[rd_ptr];
            q.out_valid = ~q.flush;
        end else if (byp) begin
            head        = in_ent;
            q.out_valid = 1'b1;
        end
    end

    // A bypassed entry taken by decode in the same cycle is never written into storage.
    assign push = q.in_valid & q.in_ready & ~q.flush & ~(byp & q.out_ready);
    assign pop  = q.out_valid & q.out_ready & ~empty;
`else
    // Head selection from storage only, so no in_* signal reaches any out_* signal.
    always_comb begin
        head        = '0;
        q.out_valid = 1'b0;
        if (!empty) begin
            head        = mem[rd_ptr];
            q.out_valid = ~q.flush;
        end
    end

    assign push = q.in_valid & q.in_ready & ~q.flush;
    assign pop  = q.out_valid & q.out_ready;
`endif

    assign q.out_pc       = head.pc;
    assign q.out_instr    = head.instr;
    assign q.out_badvaddr = head.badvaddr;
    assign q.out_inslot   = head.inslot;
    assign q.out_adel     = head.adel;

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; validity is tracked solely by count/pointers, so data needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_ent;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] bad;
        logic        inslot;
        logic        adel;
    } ent_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    instr_queue_if #(.DEPTH(DEPTH)) ifc ();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (ifc)
    );

    int   checks   = 0;
    int   failures = 0;
    ent_t mq[$];

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic slot, input logic adel, input logic [31:0] bad,
                         input logic ordy, input logic fl);
        ifc.in_valid    = v;
        ifc.in_pc       = pc;
        ifc.in_instr    = instr;
        ifc.in_inslot   = slot;
        ifc.in_adel     = adel;
        ifc.in_badvaddr = bad;
        ifc.out_ready   = ordy;
        ifc.flush       = fl;
    endtask

    // How the offered entry is expected to look once accepted.
    function automatic ent_t offered();
        ent_t e;
        e.pc     = ifc.in_pc;
        e.instr  = ifc.in_adel ? 32'h0 : ifc.in_instr;
        e.bad    = ifc.in_adel ? ifc.in_badvaddr : 32'h0;
        e.inslot = ifc.in_inslot;
        e.adel   = ifc.in_adel;
        return e;
    endfunction

    function automatic logic exp_vld();
        if (ifc.flush) return 1'b0;
        return (mq.size() > 0) || (BYP && ifc.in_valid);
    endfunction

    function automatic ent_t exp_head();
        if (mq.size() > 0) return mq[0];
        if (BYP && ifc.in_valid && !ifc.flush) return offered();
        return '0;
    endfunction

    function automatic ent_t dut_head();
        return {ifc.out_pc, ifc.out_instr, ifc.out_badvaddr, ifc.out_inslot, ifc.out_adel};
    endfunction

    // Advance one clock and apply the queue semantics to the reference model.
    task automatic tick();
        bit   fl   = ifc.flush;
        bit   emp  = (mq.size() == 0);
        bit   full = (mq.size() == DEPTH);
        bit   byp  = BYP && emp && ifc.in_valid && !fl;
        bit   vout = !fl && (!emp || byp);
        bit   pop  = vout && ifc.out_ready;
        bit   push = ifc.in_valid && !full && !fl;
        ent_t e    = offered();
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else if (!(byp && pop)) begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        mq.delete();
        #3;
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); end
        checks++; if (ifc.count !== CW'(0)) begin failures++; $display("FAIL reset_count got %0d want 0", ifc.count); end
        checks++; if (dut_head() !== ent_t'(0)) begin failures++; $display("FAIL reset_payload got %h want 0", dut_head()); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        ent_t e;
        drive(1, 32'hbfc00000, 32'h24080001, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.out_valid !== exp_vld()) begin failures++; $display("FAIL single_first_valid got %b want %b", ifc.out_valid, exp_vld()); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        e = exp_head();
        checks++; if (ifc.out_valid !== exp_vld()) begin failures++; $display("FAIL single_valid got %b want %b", ifc.out_valid, exp_vld()); end
        checks++; if (dut_head() !== e) begin failures++; $display("FAIL single_head got %h want %h", dut_head(), e); end
        tick();
        @(negedge clk);
        checks++; if (ifc.count !== CW'(0)) begin failures++; $display("FAIL single_count got %0d want 0", ifc.count); end
        tick();
    endtask

    task automatic test_fill();
        drive(1, 32'hbfc00000, 32'h11111111, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hbfc00004, 32'h22222222, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checks++; if (ifc.count !== CW'(2)) begin failures++; $display("FAIL fill_count got %0d want 2", ifc.count); end
        checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got %b want 0", ifc.in_ready); end
        drive(1, 32'hbfc00008, 32'h33333333, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.count !== CW'(2)) begin failures++; $display("FAIL fill_third_rejected got %0d want 2", ifc.count); end
        checks++; if (ifc.out_pc !== 32'hbfc00000) begin failures++; $display("FAIL fill_pop0 got %h want bfc00000", ifc.out_pc); end
        tick();
        @(negedge clk);
        checks++; if (ifc.out_pc !== 32'hbfc00004) begin failures++; $display("FAIL fill_pop1 got %h want bfc00004", ifc.out_pc); end
        tick();
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_simul();
        logic [31:0] prev = 32'hbfc00008;
        drive(1, prev, 32'h0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pcn = 32'hbfc00008 + 32'(4 * (i + 1));
            drive(1, pcn, $urandom, 0, 0, 0, 1, 0);
            @(negedge clk);
            checks++; if (ifc.out_pc !== prev) begin failures++; $display("FAIL simul_head[%0d] got %h want %h", i, ifc.out_pc, prev); end
            checks++; if (ifc.count !== CW'(1)) begin failures++; $display("FAIL simul_count[%0d] got %0d want 1", i, ifc.count); end
            tick();
            prev = pcn;
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.out_pc !== prev) begin failures++; $display("FAIL simul_last got %h want %h", ifc.out_pc, prev); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'hbfc000c0, 32'h1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hbfc000c4, 32'h2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hdead0000, 32'h3, 0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b want 0", ifc.in_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.count !== CW'(0)) begin failures++; $display("FAIL flush_count got %0d want 0", ifc.count); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid got %b want 0", ifc.out_valid); end
        tick();
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_adel();
        drive(1, 32'hbfc00002, 32'hffffffff, 0, 1, 32'hbfc00002, 0, 0);
        tick();
        drive(1, 32'hbfc00010, 32'h12345678, 1, 0, 32'hdeadbeef, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.out_adel !== 1'b1) begin failures++; $display("FAIL adel_flag got %b want 1", ifc.out_adel); end
        checks++; if (ifc.out_instr !== 32'h0) begin failures++; $display("FAIL adel_instr got %h want 0", ifc.out_instr); end
        checks++; if (ifc.out_badvaddr !== 32'hbfc00002) begin failures++; $display("FAIL adel_bad got %h want bfc00002", ifc.out_badvaddr); end
        tick();
        @(negedge clk);
        checks++; if ({ifc.out_instr, ifc.out_badvaddr, ifc.out_inslot} !== {32'h12345678, 32'h0, 1'b1})
            begin failures++; $display("FAIL noadel_fields got %h/%h/%b want 12345678/0/1", ifc.out_instr, ifc.out_badvaddr, ifc.out_inslot); end
        tick();
    endtask

`ifdef INSTR_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(1, 32'hbfc00100, 32'h24080002, 0, 0, 32'h55, 1, 0);
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL byp_valid got %b want 1", ifc.out_valid); end
        checks++; if (ifc.out_pc !== 32'hbfc00100) begin failures++; $display("FAIL byp_pc got %h want bfc00100", ifc.out_pc); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.count !== CW'(0)) begin failures++; $display("FAIL byp_count got %0d want 0", ifc.count); end
        tick();
    endtask
`endif

    task automatic test_reset_midrun();
        drive(1, 32'hbfc000e0, 32'h7, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (ifc.count !== CW'(0)) begin failures++; $display("FAIL midrst_count got %0d want 0", ifc.count); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", ifc.out_valid); end
        mq.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 32'hbfc000f0, 32'h8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (ifc.out_pc !== 32'hbfc000f0) begin failures++; $display("FAIL midrst_first got %h want bfc000f0", ifc.out_pc); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ent_t e;
            drive(($urandom % 4) != 0, $urandom, $urandom, $urandom % 2, ($urandom % 6) == 0, $urandom,
                  ($urandom % 3) != 0, ($urandom % 20) == 0);
            @(negedge clk);
            e = exp_head();
            checks++; if (ifc.out_valid !== exp_vld()) begin failures++; $display("FAIL rnd_valid[%0d] got %b want %b", i, ifc.out_valid, exp_vld()); end
            checks++; if (ifc.in_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_in_ready[%0d] got %b want %b", i, ifc.in_ready, mq.size() != DEPTH); end
            checks++; if (ifc.count !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, ifc.count, mq.size()); end
            if (!ifc.flush || mq.size() == 0) begin
                checks++; if (dut_head() !== e) begin failures++; $display("FAIL rnd_head[%0d] got %h want %h", i, dut_head(), e); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_flush();
        test_adel();
`ifdef INSTR_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of queue entries; SHALL be a power of two and at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  fetch stage offers an entry this cycle.
REQ-005 in_ready  output  1  queue accepts an entry this cycle.
REQ-006 in_pc  input  32  fetch PC of the offered instruction.
REQ-007 in_instr  input  32  instruction word from the ibus response.
REQ-008 in_inslot  input  1  instruction is in a branch delay slot.
REQ-009 in_adel  input  1  fetch address error flagged for this PC.
REQ-010 in_badvaddr  input  32  faulting fetch address; meaningful only when in_adel=1.
REQ-011 out_valid  output  1  head entry is presented to decode.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 out_pc, out_instr, out_badvaddr  output  32 each  head entry fields.
REQ-014 out_inslot, out_adel  output  1 each  head entry flags.
REQ-015 flush  input  1  discard all queued and offered entries (branch redirect or exception).
REQ-016 count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-017 Push occurs when in_valid=1, in_ready=1 and flush=0; pop occurs when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (count != DEPTH), registered-state only, with no combinational dependence on out_ready.
REQ-019 Storage SHALL be a circular buffer with read and write pointers of width log2(DEPTH) that wrap from DEPTH-1 to 0.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When count=0, out_valid SHALL be 0 (except under REQ-030) and all out_* payload fields SHALL be 0.
REQ-022 When count>0 and flush=0, out_valid SHALL be 1 and out_* SHALL show the oldest entry, in strict push order.
REQ-023 An entry pushed with in_adel=1 SHALL be stored with instr=0, and its in_badvaddr SHALL be kept; when in_adel=0, badvaddr SHALL be stored as 0.
REQ-024 flush SHALL take priority over push and pop; it SHALL force out_valid=0 in that cycle, drop any offered entry, and set count, read pointer and write pointer to 0 at the next edge.
REQ-025 While flush=1, in_ready SHALL still follow REQ-018, but no push takes effect.
REQ-026 Without bypass, latency from push to out_valid SHALL be exactly one cycle.
REQ-027 Pop with count=0 or push with count=DEPTH SHALL be impossible by construction; state SHALL NOT change in those cases.

Reset
REQ-028 resetn=0 SHALL immediately and asynchronously clear count, both pointers and all entry valid state, giving out_valid=0, in_ready=1 and out_*=0.
REQ-029 Reset asserted during operation SHALL discard all entries; the first push after deassertion SHALL land in slot 0.

Configuration
REQ-030 Macro INSTR_QUEUE_BYPASS_EN: when defined and count=0, in_valid=1 and flush=0, out_valid SHALL be 1 with out_* driven from in_* in the same cycle (with the REQ-023 masking applied); if out_ready=1, the entry SHALL NOT be stored; otherwise it SHALL be stored normally.
REQ-031 When INSTR_QUEUE_BYPASS_EN is undefined, there SHALL be no combinational path from any in_* to any out_* signal, and REQ-026 applies.

Verification
REQ-032 Reset, then push pc=0xbfc00000/instr=0x24080001, out_ready=1 -> next cycle out_valid=1, out_pc=0xbfc00000, out_instr=0x24080001; following cycle count=0.
REQ-033 out_ready=0, push 0xbfc00000 and 0xbfc00004 -> count=2, in_ready=0; a third offer is not accepted; raise out_ready -> pops occur in order 0xbfc00000 then 0xbfc00004.
REQ-034 count=1, simultaneous push of 0xbfc00008 and pop -> count stays 1 and the new head is 0xbfc00008; run 10 such cycles to cover pointer wrap.
REQ-035 count=2 with in_valid=1, assert flush for one cycle -> out_valid=0 in that cycle, count=0 next cycle, and the offered entry never appears.
REQ-036 Push in_adel=1, in_pc=0xbfc00002, in_badvaddr=0xbfc00002, in_instr=0xffffffff -> out_adel=1, out_instr=0, out_badvaddr=0xbfc00002.
REQ-037 With INSTR_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, out_ready=1 -> out_valid=1 and out_pc=in_pc in the same cycle, and count remains 0.
